// File: rtl/ym3438_host_writer_if.sv
// Request handshake and chip-bus pins of the ym3438 host writer.
interface ym3438_host_writer_if;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ADDR_W = 2;

  logic              req_valid;
  logic              req_bank;
  logic [BYTE_W-1:0] req_reg;
  logic [BYTE_W-1:0] req_val;
  logic              req_ready;
  logic              CS;
  logic              WR;
  logic              RD;
  logic [ADDR_W-1:0] address;
  logic [BYTE_W-1:0] data_out;
  logic              data_oe;
  logic [BYTE_W-1:0] data_in;
  logic [BYTE_W-1:0] status;
  logic              busy_wait;
  logic              timeout_err;
  logic              done;

  // Writer side: drives the chip pins and the request/status returns.
  modport master (
    input  req_valid, req_bank, req_reg, req_val, data_in,
    output req_ready, CS, WR, RD, address, data_out, data_oe,
           status, busy_wait, timeout_err, done
  );

  // Front-end / chip side.
  modport slave (
    output req_valid, req_bank, req_reg, req_val, data_in,
    input  req_ready, CS, WR, RD, address, data_out, data_oe,
           status, busy_wait, timeout_err, done
  );
endinterface

// File: rtl/ym3438_host_writer.sv
// Turns queued (bank, reg, val) writes into ym3438 bus cycles:
// optional busy poll, address cycle, data cycle.
module ym3438_host_writer #(
  parameter int unsigned SETUP     = 2,
  parameter int unsigned PULSE     = 4,
  parameter int unsigned HOLD      = 2,
  parameter int unsigned GAP       = 4,
  parameter int unsigned POLL_BUSY = 1,
  parameter int unsigned TIMEOUT   = 1024
) (
  input logic                  MCLK,
  input logic                  IC,
  ym3438_host_writer_if.master bus
);
  localparam int unsigned MAX_A   = (SETUP > PULSE) ? SETUP : PULSE;
  localparam int unsigned MAX_B   = (HOLD > GAP) ? HOLD : GAP;
  localparam int unsigned MAX_LEN = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);
  localparam int unsigned POLL_W  = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'((SETUP != 0) ? SETUP - 1 : 0);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'((PULSE != 0) ? PULSE - 1 : 0);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'((HOLD != 0) ? HOLD - 1 : 0);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP != 0) ? GAP - 1 : 0);

  typedef enum logic [2:0] {PH_IDLE, PH_SETUP, PH_PULSE, PH_HOLD, PH_GAP} phase_t;
  typedef enum logic [1:0] {ACC_P, ACC_A, ACC_D} acc_t;

  // Zero-length phases are skipped; PH_IDLE here marks the end of an access.
  localparam phase_t PH_FIRST       = (SETUP != 0) ? PH_SETUP : PH_PULSE;
  localparam phase_t PH_AFTER_HOLD  = (GAP != 0) ? PH_GAP : PH_IDLE;
  localparam phase_t PH_AFTER_PULSE = (HOLD != 0) ? PH_HOLD : PH_AFTER_HOLD;

  phase_t            ph, ph_d;
  acc_t              acc, acc_d;
  logic [CNT_W-1:0]  cnt, cnt_d, cnt_last;
  logic [POLL_W-1:0] poll_cnt, poll_cnt_d, poll_cnt_inc;
  logic              bank_q, bank_d;
  logic [7:0]        reg_q, reg_d, val_q, val_d;
  logic [7:0]        status_d, dout_d;
  logic [1:0]        addr_d;
  logic              timeout_d, done_d, cs_d, wr_d, rd_d, oe_d, bw_d, ready_d, act;

  // Next state, counters and the pin values for the state being entered.
  always_comb begin
    ph_d         = ph;
    acc_d        = acc;
    cnt_d        = cnt;
    poll_cnt_d   = poll_cnt;
    poll_cnt_inc = poll_cnt + POLL_W'(1);
    bank_d       = bank_q;
    reg_d        = reg_q;
    val_d        = val_q;
    status_d     = bus.status;
    timeout_d    = bus.timeout_err;
    done_d       = 1'b0;

    case (ph)
      PH_SETUP: cnt_last = SETUP_LAST;
      PH_PULSE: cnt_last = PULSE_LAST;
      PH_HOLD:  cnt_last = HOLD_LAST;
      PH_GAP:   cnt_last = GAP_LAST;
      default:  cnt_last = '0;
    endcase

    if (ph == PH_IDLE) begin
      if (bus.req_valid && bus.req_ready) begin
        bank_d     = bus.req_bank;
        reg_d      = bus.req_reg;
        val_d      = bus.req_val;
        poll_cnt_d = '0;
        timeout_d  = 1'b0;
        cnt_d      = '0;
        acc_d      = (POLL_BUSY != 0) ? ACC_P : ACC_A;
        ph_d       = PH_FIRST;
      end
    end else if (cnt != cnt_last) begin
      cnt_d = cnt + CNT_W'(1);
    end else begin
      cnt_d = '0;
      // Final edge with RD low: capture the status byte.
      if (ph == PH_PULSE && acc == ACC_P) status_d = bus.data_in;
      case (ph)
        PH_SETUP: ph_d = PH_PULSE;
        PH_PULSE: ph_d = PH_AFTER_PULSE;
        PH_HOLD:  ph_d = PH_AFTER_HOLD;
        default:  ph_d = PH_IDLE;
      endcase
      if (ph_d == PH_IDLE) begin
        case (acc)
          ACC_P: begin
            if (!status_d[7]) begin
              acc_d = ACC_A;
              ph_d  = PH_FIRST;
            end else begin
              poll_cnt_d = poll_cnt_inc;
              if (poll_cnt_inc == POLL_W'(TIMEOUT)) begin
                timeout_d = 1'b1;
                done_d    = 1'b1;
              end else begin
                ph_d = PH_FIRST;
              end
            end
          end
          ACC_A: begin
            acc_d = ACC_D;
            ph_d  = PH_FIRST;
          end
          default: done_d = 1'b1;
        endcase
      end
    end

    act     = (ph_d == PH_SETUP) || (ph_d == PH_PULSE) || (ph_d == PH_HOLD);
    cs_d    = !act;
    wr_d    = !(ph_d == PH_PULSE && acc_d != ACC_P);
    rd_d    = !(ph_d == PH_PULSE && acc_d == ACC_P);
    oe_d    = act && (acc_d != ACC_P);
    bw_d    = (ph_d != PH_IDLE) && (acc_d == ACC_P);
    ready_d = (ph_d == PH_IDLE);
    addr_d  = bus.address;
    dout_d  = bus.data_out;
    if (ph_d != PH_IDLE) begin
      addr_d = {bank_d, acc_d == ACC_D};
      if (acc_d != ACC_P) dout_d = (acc_d == ACC_D) ? val_d : reg_d;
    end
  end

  // State, counters and registered pins; IC releases the bus at once.
  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC) begin
      ph              <= PH_IDLE;
      acc             <= ACC_P;
      cnt             <= '0;
      poll_cnt        <= '0;
      bank_q          <= 1'b0;
      reg_q           <= '0;
      val_q           <= '0;
      bus.CS          <= 1'b1;
      bus.WR          <= 1'b1;
      bus.RD          <= 1'b1;
      bus.address     <= '0;
      bus.data_out    <= '0;
      bus.data_oe     <= 1'b0;
      bus.req_ready   <= 1'b1;
      bus.status      <= '0;
      bus.busy_wait   <= 1'b0;
      bus.timeout_err <= 1'b0;
      bus.done        <= 1'b0;
    end else begin
      ph              <= ph_d;
      acc             <= acc_d;
      cnt             <= cnt_d;
      poll_cnt        <= poll_cnt_d;
      bank_q          <= bank_d;
      reg_q           <= reg_d;
      val_q           <= val_d;
      bus.CS          <= cs_d;
      bus.WR          <= wr_d;
      bus.RD          <= rd_d;
      bus.address     <= addr_d;
      bus.data_out    <= dout_d;
      bus.data_oe     <= oe_d;
      bus.req_ready   <= ready_d;
      bus.status      <= status_d;
      bus.busy_wait   <= bw_d;
      bus.timeout_err <= timeout_d;
      bus.done        <= done_d;
    end
  end

  // A strobe of zero length would never move data.
  a_pulse_nonzero: assert property (@(posedge MCLK) PULSE != 0);
  // Strobes are exclusive and the writer never fights a status read.
  a_strobe_excl: assert property (@(posedge MCLK) disable iff (!IC) bus.WR || bus.RD);
  a_oe_no_read:  assert property (@(posedge MCLK) disable iff (!IC) !(bus.data_oe && !bus.RD));
endmodule

// File: tb/tb_ym3438_host_writer.sv
// Directed bench: u0 writes without polling, u1 polls busy with TIMEOUT=8.
module tb_ym3438_host_writer;
  localparam int unsigned PULSE = 4;
  localparam logic [25:0] RST_PINS = {1'b1, 1'b1, 1'b1, 2'b00, 8'h00, 1'b0, 1'b1,
                                      8'h00, 1'b0, 1'b0, 1'b0};

  typedef struct {
    bit         inst;
    bit         is_rd;
    logic [1:0] addr;
    logic [7:0] dat;
    int         len;
  } strobe_t;

  logic MCLK = 1'b0;
  logic ic0, ic1;
  int   total = 0;
  int   bad = 0;

  strobe_t    log_q[$];
  strobe_t    cur[2];
  bit         low_prev[2];
  int         inv_viol;
  int         bw_viol;
  int         rd_done1;
  int         poll_base;
  int         busy_polls;
  logic [7:0] busy_val;
  logic [7:0] idle_val;

  ym3438_host_writer_if b0 ();
  ym3438_host_writer_if b1 ();

  ym3438_host_writer #(.POLL_BUSY(0)) u0 (.MCLK(MCLK), .IC(ic0), .bus(b0.master));
  ym3438_host_writer #(.POLL_BUSY(1), .TIMEOUT(8)) u1 (.MCLK(MCLK), .IC(ic1), .bus(b1.master));

  always #5 MCLK = ~MCLK;

  // Chip model: status reads busy for the first busy_polls reads of a request.
  assign b0.data_in = 8'h00;
  always_comb b1.data_in = ((rd_done1 - poll_base) < busy_polls) ? busy_val : idle_val;

  task automatic watch(input bit i, input logic wr, input logic rd, input logic cs,
                       input logic oe, input logic bw, input logic ic,
                       input logic [1:0] a, input logic [7:0] d);
    logic low;
    low = !wr || !rd;
    if (ic) begin
      if (!wr && !rd) inv_viol++;
      if (oe && !rd) inv_viol++;
      if (!wr && cs) inv_viol++;
      if (!rd && !bw) bw_viol++;
    end
    if (low && !low_prev[i]) begin
      cur[i].inst  = i;
      cur[i].is_rd = !rd;
      cur[i].addr  = a;
      cur[i].dat   = rd ? d : 8'h00;
      cur[i].len   = 1;
    end else if (low) begin
      cur[i].len++;
    end else if (low_prev[i]) begin
      log_q.push_back(cur[i]);
      if (i && cur[i].is_rd) rd_done1++;
    end
    low_prev[i] = low;
  endtask

  // Strobe logger and pin invariants, sampled mid-cycle.
  always @(negedge MCLK) begin
    watch(1'b0, b0.WR, b0.RD, b0.CS, b0.data_oe, b0.busy_wait, ic0, b0.address, b0.data_out);
    watch(1'b1, b1.WR, b1.RD, b1.CS, b1.data_oe, b1.busy_wait, ic1, b1.address, b1.data_out);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input bit inst, input bit is_rd, input logic [1:0] a,
                                      input logic [7:0] d, input int len);
    return {3'd0, inst, 3'd0, is_rd, 6'd0, a, d, len[7:0]};
  endfunction

  task automatic chk_strobe(input string tag, input int idx, input bit inst, input bit is_rd,
                            input logic [1:0] a, input logic [7:0] d);
    if (idx < log_q.size())
      chk(tag, enc(log_q[idx].inst, log_q[idx].is_rd, log_q[idx].addr, log_q[idx].dat,
                   log_q[idx].len), enc(inst, is_rd, a, d, PULSE));
    else
      chk(tag, 32'hFFFF_FFFF, enc(inst, is_rd, a, d, PULSE));
  endtask

  function automatic logic [25:0] pins(input bit sel);
    if (sel)
      return {b1.CS, b1.WR, b1.RD, b1.address, b1.data_out, b1.data_oe, b1.req_ready,
              b1.status, b1.busy_wait, b1.timeout_err, b1.done};
    return {b0.CS, b0.WR, b0.RD, b0.address, b0.data_out, b0.data_oe, b0.req_ready,
            b0.status, b0.busy_wait, b0.timeout_err, b0.done};
  endfunction

  // Present one request for a single edge; returns at the negedge after accept.
  task automatic send(input bit sel, input bit bank, input logic [7:0] r, input logic [7:0] v);
    if (sel) begin
      b1.req_bank = bank; b1.req_reg = r; b1.req_val = v; b1.req_valid = 1'b1;
    end else begin
      b0.req_bank = bank; b0.req_reg = r; b0.req_val = v; b0.req_valid = 1'b1;
    end
    @(negedge MCLK);
    if (sel) b1.req_valid = 1'b0;
    else     b0.req_valid = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input int bound, output int lat);
    lat = -1;
    for (int k = 1; k <= bound; k++) begin
      @(negedge MCLK);
      if ((sel ? b1.done : b0.done) === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int base;
    int nw;
    int found;
    ic0 = 1'b0; ic1 = 1'b0;
    b0.req_valid = 1'b0; b0.req_bank = 1'b0; b0.req_reg = '0; b0.req_val = '0;
    b1.req_valid = 1'b0; b1.req_bank = 1'b0; b1.req_reg = '0; b1.req_val = '0;
    busy_polls = 0; poll_base = 0; busy_val = 8'h80; idle_val = 8'h00;
    repeat (2) @(negedge MCLK);
    chk("rst_u0", pins(1'b0), RST_PINS);
    chk("rst_u1", pins(1'b1), RST_PINS);
    ic0 = 1'b1; ic1 = 1'b1;
    @(negedge MCLK);

    // Plain write, no polling.
    base = log_q.size();
    send(1'b0, 1'b0, 8'h28, 8'hF0);
    chk("t1_ready_drop", b0.req_ready, 1'b0);
    wait_done(1'b0, 100, lat);
    chk("t1_latency", lat, 24);
    chk("t1_ready_at_done", b0.req_ready, 1'b1);
    chk("t1_nstrobe", log_q.size() - base, 2);
    chk_strobe("t1_addr_cycle", base, 1'b0, 1'b0, 2'd0, 8'h28);
    chk_strobe("t1_data_cycle", base + 1, 1'b0, 1'b0, 2'd1, 8'hF0);
    @(negedge MCLK);
    chk("t1_done_pulse", b0.done, 1'b0);

    // Three busy polls then ready.
    poll_base = rd_done1; busy_polls = 3; idle_val = 8'h00;
    base = log_q.size();
    send(1'b1, 1'b1, 8'h30, 8'h71);
    chk("t2_busy_wait", b1.busy_wait, 1'b1);
    wait_done(1'b1, 200, lat);
    chk("t2_latency", lat, 72);
    chk("t2_nstrobe", log_q.size() - base, 6);
    for (int i = 0; i < 4; i++)
      chk_strobe($sformatf("t2_poll%0d", i), base + i, 1'b1, 1'b1, 2'd2, 8'h00);
    chk_strobe("t2_addr_cycle", base + 4, 1'b1, 1'b0, 2'd2, 8'h30);
    chk_strobe("t2_data_cycle", base + 5, 1'b1, 1'b0, 2'd3, 8'h71);
    chk("t2_status", b1.status, 8'h00);
    chk("t2_busy_wait_end", b1.busy_wait, 1'b0);
    @(negedge MCLK);

    // Chip stays busy: give up after 8 reads.
    poll_base = rd_done1; busy_polls = 1000;
    base = log_q.size();
    send(1'b1, 1'b0, 8'h11, 8'h22);
    wait_done(1'b1, 300, lat);
    chk("t3_latency", lat, 96);
    chk("t3_timeout_err", b1.timeout_err, 1'b1);
    chk("t3_nstrobe", log_q.size() - base, 8);
    nw = 0;
    for (int i = base; i < log_q.size(); i++) if (!log_q[i].is_rd) nw++;
    chk("t3_no_write", nw, 0);
    for (int i = 0; i < 8; i++)
      chk_strobe($sformatf("t3_poll%0d", i), base + i, 1'b1, 1'b1, 2'd0, 8'h00);
    @(negedge MCLK);
    chk("t3_err_sticky", {b1.timeout_err, b1.done}, 2'b10);

    // Non-busy status with low bits set; also clears the sticky error.
    poll_base = rd_done1; busy_polls = 0; idle_val = 8'h03;
    base = log_q.size();
    send(1'b1, 1'b1, 8'h55, 8'hAA);
    chk("t6_err_cleared", b1.timeout_err, 1'b0);
    wait_done(1'b1, 200, lat);
    chk("t6_latency", lat, 36);
    chk("t6_status", b1.status, 8'h03);
    chk("t6_nstrobe", log_q.size() - base, 3);
    chk_strobe("t6_poll", base, 1'b1, 1'b1, 2'd2, 8'h00);
    chk_strobe("t6_addr_cycle", base + 1, 1'b1, 1'b0, 2'd2, 8'h55);
    chk_strobe("t6_data_cycle", base + 2, 1'b1, 1'b0, 2'd3, 8'hAA);
    @(negedge MCLK);

    // Reset in the middle of the address strobe.
    send(1'b0, 1'b1, 8'hB4, 8'hC0);
    found = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge MCLK);
      if (b0.WR === 1'b0) begin
        found = 1;
        break;
      end
    end
    chk("t4_reach_pulse", found, 1);
    @(negedge MCLK);
    ic0 = 1'b0;
    #1;
    chk("t4_abort_pins", pins(1'b0), RST_PINS);
    repeat (2) @(negedge MCLK);
    ic0 = 1'b1;
    @(negedge MCLK);
    base = log_q.size();
    send(1'b0, 1'b0, 8'h2B, 8'h80);
    wait_done(1'b0, 100, lat);
    chk("t4_latency", lat, 24);
    chk("t4_nstrobe", log_q.size() - base, 2);
    chk_strobe("t4_addr_cycle", base, 1'b0, 1'b0, 2'd0, 8'h2B);
    chk_strobe("t4_data_cycle", base + 1, 1'b0, 1'b0, 2'd1, 8'h80);
    @(negedge MCLK);

    // Back-to-back with req_valid held high.
    base = log_q.size();
    b0.req_bank = 1'b0; b0.req_reg = 8'h22; b0.req_val = 8'h01; b0.req_valid = 1'b1;
    @(negedge MCLK);
    chk("t5_first_accept", b0.req_ready, 1'b0);
    b0.req_bank = 1'b1; b0.req_reg = 8'hA0; b0.req_val = 8'h33;
    wait_done(1'b0, 100, lat);
    chk("t5_latency1", lat, 24);
    @(negedge MCLK);
    chk("t5_second_accept", {b0.req_ready, b0.done, b0.CS}, 3'b000);
    b0.req_valid = 1'b0;
    wait_done(1'b0, 100, lat);
    chk("t5_latency2", lat, 24);
    chk("t5_nstrobe", log_q.size() - base, 4);
    chk_strobe("t5_a1", base, 1'b0, 1'b0, 2'd0, 8'h22);
    chk_strobe("t5_d1", base + 1, 1'b0, 1'b0, 2'd1, 8'h01);
    chk_strobe("t5_a2", base + 2, 1'b0, 1'b0, 2'd2, 8'hA0);
    chk_strobe("t5_d2", base + 3, 1'b0, 1'b0, 2'd3, 8'h33);
    @(negedge MCLK);

    chk("inv_bus_pins", inv_viol, 0);
    chk("inv_busy_wait", bw_viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ym3438_host_writer.md
Name: ym3438_host_writer

Overview:
- Host-side bus initiator for the ym3438 CPU interface.
- Accepts queued register-write requests (bank, register, value) and converts each into the chip bus sequence: optional status poll until not busy, then an address cycle, then a data cycle.
- Sits between a sequencer/CPU-emulation front end and the chip's CS/WR/RD/address/data pins.
- Provides status capture and a timeout error for stalled busy polling.

Parameters:
- SETUP, 2: MCLK cycles with CS low, WR/RD high, address/data valid before the strobe.
- PULSE, 4: MCLK cycles the WR or RD strobe is held low.
- HOLD, 2: MCLK cycles after the strobe rises with CS still low and data still driven.
- GAP, 4: MCLK cycles with CS high between accesses.
- POLL_BUSY, 1: 1 = poll status bit 7 before each address cycle; 0 = skip polling.
- TIMEOUT, 1024: maximum poll reads per request before the error is raised.

Ports:
- MCLK  in  1  clock.
- IC  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_bank  in  1  0 = port 0 (address 0/1), 1 = port 1 (address 2/3).
- req_reg  in  8  register number.
- req_val  in  8  register value.
- req_ready  out  1  high in IDLE; a request is accepted when req_valid & req_ready on a rising MCLK edge.
- CS  out  1  chip select, active low.
- WR  out  1  write strobe, active low.
- RD  out  1  read strobe, active low.
- address  out  2  chip address pins.
- data_out  out  8  bus write data.
- data_oe  out  1  1 = data_out is driven onto the bus.
- data_in  in  8  bus read data (status).
- status  out  8  last status byte sampled.
- busy_wait  out  1  high while polling.
- timeout_err  out  1  sticky error; cleared on the next accepted request.
- done  out  1  single-cycle pulse when a request completes or is abandoned.

Behaviour:
- Reset (IC low, asynchronous): state IDLE.
  - Outputs: CS=1, WR=1, RD=1, address=0, data_out=0, data_oe=0, req_ready=1, status=0, busy_wait=0, timeout_err=0, done=0.
  - All counters are cleared.
  - A reset asserted mid-access aborts it immediately; the bus is released on the same edge.
- Acceptance: on accept, latch bank/reg/val, clear the poll counter and timeout_err, and drop req_ready.
  - Next state: P_SETUP if POLL_BUSY=1, otherwise A_SETUP.
- Generic access (X = P, A or D):
  - X_SETUP: lasts SETUP cycles. CS=0, address valid; for A and D, data_oe=1.
  - X_PULSE: lasts PULSE cycles. RD=0 for P, WR=0 for A and D.
  - X_HOLD: lasts HOLD cycles. Strobe high, CS=0, data still driven.
  - X_GAP: lasts GAP cycles. CS=1, data_oe=0, address held.
  - All outputs are registered and change only on state transitions.
- Poll access (P):
  - address = {bank,0}, data_oe=0, busy_wait=1.
  - status <= data_in on the last PULSE cycle (the final edge with RD=0).
  - After P_GAP: if status[7]=0, go to A_SETUP.
  - Else increment the poll counter. If the counter reaches TIMEOUT, set timeout_err, pulse done, go to IDLE and skip the write. Otherwise repeat P_SETUP.
- Address access (A): address = {bank,0}, data_out = reg.
- Data access (D): address = {bank,1}, data_out = val.
  - After D_GAP: done=1 for one cycle, return to IDLE, req_ready=1 on that same cycle.
- Latency with no poll: SETUP+PULSE+HOLD+GAP per access = 12 cycles each at defaults.
  - Accept edge to done = 24 cycles with POLL_BUSY=0, 36 cycles with one non-busy poll.
- Phase counter: width clog2(max(SETUP,PULSE,HOLD,GAP)+1).
  - A parameter value of 0 skips that phase.
  - PULSE must be at least 1 (checked by assertion).
- Invariants:
  - WR and RD are never low together.
  - data_oe=1 only in A/D phases, never while RD=0.
  - CS is high whenever both WR and RD are high and the state is IDLE or GAP.
- req_valid changes while a request is busy are ignored. Back-to-back requests are separated by GAP plus one IDLE cycle.

Test Plan:
- POLL_BUSY=0, IC high, request bank=0 reg=0x28 val=0xF0. Required response:
  - WR low for 4 cycles with address=0 and data_out=0x28.
  - Then WR low for 4 cycles with address=1 and data_out=0xF0.
  - done exactly 24 cycles after accept.
- POLL_BUSY=1, data_in=0x80 for the first 3 poll reads, then 0x00, request bank=1 reg=0x30 val=0x71. Required response:
  - 4 RD strobes at address=2, with busy_wait high throughout polling.
  - Then writes at address 2 (0x30) and address 3 (0x71).
  - status=0x00 at the end.
- TIMEOUT=8, data_in held at 0x80. Required response:
  - Exactly 8 RD strobes, timeout_err=1, done pulse, no WR strobe.
  - The next accepted request clears timeout_err.
- IC pulled low during the A_PULSE phase. Required response:
  - Same edge: WR=1, CS=1, data_oe=0, req_ready=1.
  - After IC rises, a new request runs a full, normal sequence.
- Two requests presented back-to-back with req_valid held high. Required response:
  - Second accept occurs one cycle after the first done.
  - Checker confirms WR&RD never both low and data_oe=0 whenever RD=0 across the whole run.
- data_in=0x03 on a non-busy poll. Required response: status=0x03 latched and the write proceeds immediately.
